// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry front-end: key codes, operator
// encodings, sequencer states and the operand magnitude limit.
package calc_pkg;

    localparam logic [4:0] KEY_PLUS  = 5'd10;
    localparam logic [4:0] KEY_MINUS = 5'd11;
    localparam logic [4:0] KEY_EQ    = 5'd12;
    localparam logic [4:0] KEY_CLR   = 5'd13;
    localparam logic [4:0] KEY_NEG   = 5'd14;
    localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic {
        ENTRY = 1'b0,
        ISSUE = 1'b1
    } seq_state_t;

    // Largest magnitude representable as a positive W-bit two's-complement value.
    function automatic int max_mag(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/calc_operand_accum.sv
// Decimal operand accumulator: builds the magnitude digit by digit, saturating with
// a sticky overflow flag. Build option CALC_NEGATE_EN enables the sign toggle.
module calc_operand_accum
    import calc_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         digit_strobe,
    input  logic [3:0]   digit,
    input  logic         negate_strobe,
    input  logic         clear_strobe,
    output logic [W:0]   value,
    output logic         started
);

    localparam logic [W+3:0] MAXMAG_EXT = (W + 4)'(max_mag(W));

    logic [W-1:0] mag;
    logic         sign;
    logic         ovf;
    logic [W+3:0] mag_ext;
    logic [W+3:0] nxt;
    logic [W-1:0] mag_neg;

    // mag*10 + d without a multiplier; the 4 extra bits cannot overflow.
    always_comb begin
        mag_ext = {4'b0000, mag};
        nxt     = (mag_ext << 3) + (mag_ext << 1) + {{W{1'b0}}, digit};
    end

    always_ff @(posedge clk) begin
        if (rst || clear_strobe) begin
            mag     <= '0;
            sign    <= 1'b0;
            ovf     <= 1'b0;
            started <= 1'b0;
        end else begin
            if (digit_strobe) begin
                started <= 1'b1;
                if (!ovf) begin
                    if (nxt > MAXMAG_EXT) begin
                        mag <= MAXMAG_EXT[W-1:0];
                        ovf <= 1'b1;
                    end else begin
                        mag <= nxt[W-1:0];
                    end
                end
            end
`ifdef CALC_NEGATE_EN
            if (negate_strobe) begin
                sign <= ~sign;
            end
`endif
        end
    end

`ifndef CALC_NEGATE_EN
    logic negate_unused;
    assign negate_unused = negate_strobe;
`endif

    assign mag_neg = (~mag) + {{(W-1){1'b0}}, 1'b1};
    assign value   = {ovf, sign ? mag_neg : mag};

endmodule

// File: rtl/calc_entry_sequencer.sv
// Keypad front-end: collects up to three operands and two operators, then holds the
// expression on a valid/ready port. Build option CALC_NEGATE_EN enables key 14 (negate).
module calc_entry_sequencer
    import calc_pkg::*;
#(
    parameter int W       = 10,
    parameter int MAX_OPS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [4:0]   key_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   a,
    output logic [W:0]   b,
    output logic [W:0]   c,
    output logic [1:0]   op0,
    output logic [1:0]   op1,
    output logic [1:0]   n_operands,
    output logic [W:0]   entry_value
);

    localparam logic [1:0] LAST_IDX = 2'(MAX_OPS - 1);

    seq_state_t   state;
    seq_state_t   next_state;
    logic [1:0]   idx;
    logic [1:0]   n_q;
    logic [W:0]   opnd [MAX_OPS];
    logic [1:0]   ops  [MAX_OPS-1];

    logic         digit_strobe;
    logic         negate_strobe;
    logic         capture_op;
    logic         rewrite_op;
    logic         capture_eq;
    logic         clear_all;
    logic         acc_clear;
    logic [W:0]   acc_value;
    logic         acc_started;
    logic [1:0]   key_op;

    assign key_op    = (key_code == KEY_MINUS) ? OP_SUB : OP_ADD;
    assign acc_clear = clear_all | capture_op | capture_eq;

    calc_operand_accum #(
        .W (W)
    ) u_accum (
        .clk           (clk),
        .rst           (rst),
        .digit_strobe  (digit_strobe),
        .digit         (key_code[3:0]),
        .negate_strobe (negate_strobe),
        .clear_strobe  (acc_clear),
        .value         (acc_value),
        .started       (acc_started)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ENTRY;
        end else begin
            state <= next_state;
        end
    end

    // Keys only act in ENTRY; ISSUE waits for the downstream accept and ignores the keypad.
    always_comb begin
        next_state    = state;
        digit_strobe  = 1'b0;
        negate_strobe = 1'b0;
        capture_op    = 1'b0;
        rewrite_op    = 1'b0;
        capture_eq    = 1'b0;
        clear_all     = 1'b0;
        case (state)
            ENTRY: begin
                if (key_valid) begin
                    if (key_code <= KEY_DIGIT_MAX) begin
                        digit_strobe = 1'b1;
                    end else if (key_code == KEY_PLUS || key_code == KEY_MINUS) begin
                        if (idx < LAST_IDX) begin
                            if (acc_started) begin
                                capture_op = 1'b1;
                            end else if (idx != 2'd0) begin
                                rewrite_op = 1'b1;
                            end
                        end
                    end else if (key_code == KEY_EQ) begin
                        capture_eq = 1'b1;
                        next_state = ISSUE;
                    end else if (key_code == KEY_CLR) begin
                        clear_all = 1'b1;
                    end else if (key_code == KEY_NEG) begin
                        negate_strobe = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    clear_all  = 1'b1;
                    next_state = ENTRY;
                end
            end
            default: begin
                next_state = ENTRY;
            end
        endcase
    end

    // A second operator before any digit replaces the previous operator instead of capturing.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            idx <= 2'd0;
            n_q <= 2'd0;
            for (int i = 0; i < MAX_OPS; i++) begin
                opnd[i] <= '0;
            end
            for (int i = 0; i < MAX_OPS - 1; i++) begin
                ops[i] <= OP_ADD;
            end
        end else if (capture_op) begin
            opnd[idx]    <= acc_value;
            ops[idx[0]]  <= key_op;
            idx          <= idx + 2'd1;
        end else if (rewrite_op) begin
            ops[idx[0] - 1'b1] <= key_op;
        end else if (capture_eq) begin
            opnd[idx] <= acc_value;
            n_q       <= idx + 2'd1;
        end
    end

    assign out_valid   = (state == ISSUE);
    assign a           = out_valid ? opnd[0] : '0;
    assign b           = out_valid ? opnd[1] : '0;
    assign c           = out_valid ? opnd[2] : '0;
    assign op0         = out_valid ? ops[0]  : 2'b00;
    assign op1         = out_valid ? ops[1]  : 2'b00;
    assign n_operands  = out_valid ? n_q     : 2'b00;
    assign entry_value = acc_value;

endmodule
